mem_stage: RTL and testbench

Memory-access pipeline stage sitting directly downstream of the execute stage. It registers the execute-to-memory bus under the global stall vector, and captures the synchronous data-SRAM read word. It aligns and extends load data, then selects the write-back value. It drives the memory-to-writeback bus and a same-cycle forwarding bus back to decode.

---
 rtl/mem_stage_pkg.sv | 41 ++++
 rtl/load_align.sv | 37 +++
 rtl/mem_stage.sv | 69 ++++++
 tb/tb_mem_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, stall polarity,
// load opcodes and the decoded execute-to-memory bus layout.
package mem_stage_pkg;

  localparam int EX_TO_MEM_BUS_WD = 79;
  localparam int MEM_TO_WB_BUS_WD = 70;
  localparam int MEM_TO_RF_BUS_WD = 38;
  localparam int STALL_BUS_WD     = 6;
  localparam int STALL_MEM_BIT    = 3;
  localparam int STALL_WB_BIT     = 4;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [2:0] {
    MEM_LW  = 3'b000,
    MEM_LB  = 3'b001,
    MEM_LBU = 3'b010,
    MEM_LH  = 3'b011,
    MEM_LHU = 3'b100
  } mem_op_e;

  typedef struct packed {
    logic [31:0] pc;
    mem_op_e     mem_op;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  // A load is an enabled data-RAM access with no byte write enables.
  function automatic logic is_load(input ex_to_mem_t b);
    return b.data_ram_en && (b.data_ram_wen == 4'b0000);
  endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian load alignment: picks the byte/halfword addressed by addr
// out of the read word and sign- or zero-extends it to 32 bits.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  mem_op_e     mem_op,
  output logic [31:0] result
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = word[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[addr];
  // addr[0] is don't-care for halfwords; misalignment is trapped upstream.
  assign half_sel = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = word;
    case (mem_op)
      MEM_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: result = {24'h000000, byte_sel};
      MEM_LH:  result = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: result = {16'h0000, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus under stall control,
// freezes the SRAM read word across stalls, and builds the WB/forwarding buses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int EX_TO_MEM_WD = EX_TO_MEM_BUS_WD,
  parameter int MEM_TO_WB_WD = MEM_TO_WB_BUS_WD,
  parameter int STALL_WD     = STALL_BUS_WD
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_BUS_WD-1:0] mem_to_rf_bus
);

  logic [EX_TO_MEM_WD-1:0] bus_reg;
  logic                    held_reg;
  logic [31:0]             rdata_buf_reg;

  ex_to_mem_t  ex;
  logic        stall_mem;
  logic        stall_wb;
  logic [31:0] rdata_eff;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        unused_stall;

  assign stall_mem    = stall[STALL_MEM_BIT];
  assign stall_wb     = stall[STALL_WB_BIT];
  assign unused_stall = ^{stall[STALL_WD-1:STALL_WB_BIT+1], stall[STALL_MEM_BIT-1:0]};

  assign ex = ex_to_mem_t'(bus_reg);

  // The SRAM word is only valid for one cycle, so the first held edge of a
  // load latches it; later stalled cycles replay the latched copy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_reg       <= '0;
      held_reg      <= 1'b0;
      rdata_buf_reg <= ZeroWord;
    end else if (stall_mem == Stop && stall_wb == NoStop) begin
      bus_reg  <= '0;
      held_reg <= 1'b0;
    end else if (stall_mem == NoStop) begin
      bus_reg  <= ex_to_mem_bus;
      held_reg <= 1'b0;
    end else if (is_load(ex) && !held_reg) begin
      held_reg      <= 1'b1;
      rdata_buf_reg <= data_sram_rdata;
    end
  end

  assign rdata_eff = held_reg ? rdata_buf_reg : data_sram_rdata;

  load_align u_load_align (
    .word   (rdata_eff),
    .addr   (ex.ex_result[1:0]),
    .mem_op (ex.mem_op),
    .result (load_data)
  );

  assign rf_wdata      = ex.sel_rf_res ? load_data : ex.ex_result;
  assign mem_to_rf_bus = {ex.rf_we, ex.rf_waddr, rf_wdata};
  assign mem_to_wb_bus = {ex.pc, mem_to_rf_bus};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized run
// compared against a transaction-level model of the stage.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic [5:0]  stall;
  logic [78:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;

  int checks = 0;
  int errors = 0;

  // Model: the instruction currently in MEM, plus a frozen read word.
  logic [78:0] m_bus;
  logic        m_held;
  logic [31:0] m_buf;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_rf_bus   (mem_to_rf_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [78:0] make_bus(input logic [31:0] pc, input logic [2:0] op,
                                           input logic en, input logic [3:0] wen,
                                           input logic sel, input logic we,
                                           input logic [4:0] waddr, input logic [31:0] res);
    return {pc, op, en, wen, sel, we, waddr, res};
  endfunction

  // Write-back value from the load rules, computed with plain arithmetic.
  function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [1:0] addr,
                                            input logic [31:0] word, input logic sel,
                                            input logic [31:0] res);
    logic [31:0] b;
    logic [31:0] h;
    if (!sel) return res;
    b = (word >> (8 * addr)) & 32'hFF;
    h = (word >> (16 * (addr / 2))) & 32'hFFFF;
    case (op)
      3'd1: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd2: return b;
      3'd3: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4: return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [37:0] model_rf();
    logic [31:0] word;
    word = m_held ? m_buf : data_sram_rdata;
    return {m_bus[37], m_bus[36:32],
            ref_wdata(m_bus[46:44], m_bus[1:0], word, m_bus[38], m_bus[31:0])};
  endfunction

  // Advance one clock edge, moving the model with the inputs seen at that edge.
  task automatic tick();
    logic [78:0] nb;
    logic        nh;
    logic [31:0] nbuf;
    nb = m_bus; nh = m_held; nbuf = m_buf;
    if (!resetn) begin
      nb = '0; nh = 1'b0; nbuf = '0;
    end else if (stall[3] && !stall[4]) begin
      nb = '0; nh = 1'b0;
    end else if (!stall[3]) begin
      nb = ex_to_mem_bus; nh = 1'b0;
    end else if (m_bus[43] && m_bus[42:39] == 4'd0 && !m_held) begin
      nh = 1'b1; nbuf = data_sram_rdata;
    end
    @(posedge clk);
    m_bus = nb; m_held = nh; m_buf = nbuf;
    #1;
  endtask

  task automatic test_reset();
    logic [78:0] b;
    resetn = 1'b0;
    stall = 6'd0;
    b = make_bus($urandom, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'($urandom), $urandom);
    ex_to_mem_bus = b;
    data_sram_rdata = $urandom;
    tick(); tick();
    #1;
    checks++;
    if (mem_to_wb_bus !== 70'd0) begin
      errors++;
      $display("FAIL reset_wb: got %h expected 0", mem_to_wb_bus);
    end
    checks++;
    if (mem_to_rf_bus !== 38'd0) begin
      errors++;
      $display("FAIL reset_rf: got %h expected 0", mem_to_rf_bus);
    end
    resetn = 1'b1;
    tick();
    #1;
    checks++;
    if (mem_to_wb_bus !== {b[78:47], b[37], b[36:32], b[31:0]}) begin
      errors++;
      $display("FAIL reset_release_load: got %h expected %h", mem_to_wb_bus,
               {b[78:47], b[37], b[36:32], b[31:0]});
    end
    $display("reset: bus after release pc=%h", mem_to_wb_bus[69:38]);
  endtask

  task automatic test_load_align();
    logic [2:0]  ops   [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd3, 3'd7};
    logic [1:0]  addrs [8] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd3, 2'd3, 2'd1};
    logic [31:0] words [8] = '{32'h1280_5634, 32'h1280_5634, 32'h8001_7FFF, 32'h8001_7FFF,
                               32'h8001_7FFF, 32'h1280_5634, 32'h8001_7FFF, 32'hCAFE_F00D};
    logic [31:0] exps  [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_7FFF,
                               32'h8001_7FFF, 32'h0000_0012, 32'hFFFF_8001, 32'hCAFE_F00D};
    string       names [8] = '{"lb", "lbu", "lh", "lhu", "lw", "lb_addr3", "lh_addr3", "op7_lw"};
    for (int i = 0; i < 8; i++) begin
      stall = 6'd0;
      ex_to_mem_bus = make_bus($urandom, ops[i], 1'b1, 4'd0, 1'b1, 1'b1, 5'($urandom),
                               {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | 32'(addrs[i]));
      tick();
      data_sram_rdata = words[i];
      #1;
      checks++;
      if (mem_to_rf_bus[31:0] !== exps[i]) begin
        errors++;
        $display("FAIL align_%s: got %h expected %h", names[i], mem_to_rf_bus[31:0], exps[i]);
      end else
        $display("align %s: rdata=%h rf_wdata=%h", names[i], words[i], mem_to_rf_bus[31:0]);
    end
  endtask

  task automatic test_stalled_load();
    logic [37:0] first_rf;
    stall = 6'd0;
    ex_to_mem_bus = make_bus(32'h0000_1000, 3'd0, 1'b1, 4'd0, 1'b1, 1'b1, 5'd9, 32'h0000_2000);
    tick();
    data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (mem_to_rf_bus[31:0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL stall_first: got %h expected deadbeef", mem_to_rf_bus[31:0]);
    end
    first_rf = mem_to_rf_bus;
    stall = 6'b011000;
    ex_to_mem_bus = make_bus(32'h0000_5555, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd3, 32'h7);
    for (int c = 0; c < 3; c++) begin
      tick();
      data_sram_rdata = 32'h1111_1111;
      #1;
      checks++;
      if (mem_to_rf_bus !== {1'b1, 5'd9, 32'hDEAD_BEEF} || mem_to_rf_bus !== first_rf) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %h expected %h", c, mem_to_rf_bus,
                 {1'b1, 5'd9, 32'hDEAD_BEEF});
      end else
        $display("stall cycle %0d: rf_bus=%h", c, mem_to_rf_bus);
    end
    // Asynchronous reset in the middle of a stall.
    #2;
    resetn = 1'b0;
    m_bus = '0; m_held = 1'b0; m_buf = '0;
    #1;
    checks++;
    if (mem_to_wb_bus !== 70'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", mem_to_wb_bus);
    end
    resetn = 1'b1;
    stall = 6'd0;
    tick();
  endtask

  task automatic test_bubble();
    stall = 6'd0;
    ex_to_mem_bus = make_bus(32'h0000_2000, 3'd0, 1'b1, 4'd0, 1'b1, 1'b1, 5'd4, 32'h100);
    tick();
    data_sram_rdata = 32'hAAAA_0001;
    stall = 6'b011000;
    tick();
    data_sram_rdata = 32'hBBBB_0002;
    stall = 6'b001000;
    tick();
    #1;
    checks++;
    if (mem_to_wb_bus !== 70'd0 || mem_to_rf_bus[37] !== 1'b0) begin
      errors++;
      $display("FAIL bubble: got %h expected 0", mem_to_wb_bus);
    end else
      $display("bubble: wb_bus=%h", mem_to_wb_bus);
    stall = 6'd0;
    ex_to_mem_bus = make_bus(32'h0000_2004, 3'd0, 1'b1, 4'd0, 1'b1, 1'b1, 5'd6, 32'h104);
    tick();
    data_sram_rdata = 32'hCCCC_0003;
    #1;
    checks++;
    if (mem_to_rf_bus !== {1'b1, 5'd6, 32'hCCCC_0003}) begin
      errors++;
      $display("FAIL after_bubble: got %h expected %h", mem_to_rf_bus,
               {1'b1, 5'd6, 32'hCCCC_0003});
    end else
      $display("after bubble: rf_bus=%h", mem_to_rf_bus);
  endtask

  task automatic test_alu();
    stall = 6'd0;
    ex_to_mem_bus = make_bus(32'h0040_1234, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd5, 32'h0000_0042);
    tick();
    data_sram_rdata = $urandom;
    #1;
    checks++;
    if (mem_to_rf_bus !== {1'b1, 5'd5, 32'h42}) begin
      errors++;
      $display("FAIL alu_rf: got %h expected %h", mem_to_rf_bus, {1'b1, 5'd5, 32'h42});
    end
    checks++;
    if (mem_to_wb_bus !== {32'h0040_1234, 1'b1, 5'd5, 32'h42}) begin
      errors++;
      $display("FAIL alu_wb: got %h expected %h", mem_to_wb_bus,
               {32'h0040_1234, 1'b1, 5'd5, 32'h42});
    end else
      $display("alu: wb_bus=%h", mem_to_wb_bus);
  endtask

  task automatic test_random();
    logic [3:0]  wen;
    logic        en;
    logic [37:0] exp_rf;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0:       stall = 6'($urandom) | 6'b001000 & ~6'b010000;
        1, 2:    stall = 6'($urandom) | 6'b011000;
        default: stall = 6'($urandom) & ~6'b001000;
      endcase
      en  = ($urandom_range(0, 2) != 0);
      wen = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      ex_to_mem_bus = make_bus($urandom, 3'($urandom), en, wen,
                               (en && wen == 4'd0) ? 1'($urandom) : 1'b0,
                               1'($urandom), 5'($urandom), $urandom);
      tick();
      data_sram_rdata = $urandom;
      #1;
      exp_rf = model_rf();
      checks++;
      if (mem_to_wb_bus !== {m_bus[78:47], exp_rf}) begin
        errors++;
        $display("FAIL random_%0d: got %h expected %h", i, mem_to_wb_bus,
                 {m_bus[78:47], exp_rf});
      end
      checks++;
      if (mem_to_rf_bus !== exp_rf) begin
        errors++;
        $display("FAIL random_rf_%0d: got %h expected %h", i, mem_to_rf_bus, exp_rf);
      end
      if (i % 50 == 0)
        $display("random %0d: stall=%b wb_bus=%h", i, stall, mem_to_wb_bus);
    end
  endtask

  initial begin
    resetn = 1'b0;
    stall = 6'd0;
    ex_to_mem_bus = '0;
    data_sram_rdata = '0;
    m_bus = '0; m_held = 1'b0; m_buf = '0;
    test_reset();
    test_load_align();
    test_stalled_load();
    test_bubble();
    test_alu();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
